fetch_queue: RTL

- Instruction-fetch front end that replaces the free-running PC register and +4 adder feeding instruction memory.
- Generates fetch addresses and issues them to the synchronous-read instruction memory.
- Captures returned instruction words into a DEPTH-entry FIFO and presents them, with their PC, to decode/register-bank read through a valid/ready handshake.
- Supports stall by back-pressure and branch/jump redirect with flush.

---
 rtl/fetch_queue.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetch addresses to a synchronous-read
// instruction memory and buffers returned words with their PC for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: the head entry transfers on a cycle where instr_valid and instr_ready
    // are both high; instr_valid never depends on instr_ready.

    logic [31:0]   fetch_pc;
    logic [31:0]   addr_q;
    logic          req_q;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          push;
    logic          pop;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    // In-flight request reserves a slot; the current pop is not credited, so a
    // response can always be written without checking for full.
    assign occupancy = {1'b0, count} + (CW + 1)'(req_q);
    assign imem_req  = rst & ~redirect & (occupancy < (CW + 1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

    assign push = req_q & ~redirect;
    assign pop  = instr_valid & instr_ready & ~redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            addr_q   <= 32'h0;
            req_q    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            req_q    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            req_q <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + PC_INC;
                addr_q   <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= addr_q;
        end
    end

endmodule
